// File: rtl/id_ex_buf.sv
// Elastic decode->execute buffer: DEPTH-entry FIFO of packed payloads with flush
// and a global freeze (rdy). An empty buffer presents an all-zero payload (NOP).

module id_ex_buf_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] data_q;

  // Storage is deliberately not reset; the head read is masked while empty.
  always_ff @(posedge clk) begin
    if (we) data_q <= d;
  end

  assign q = data_q;
endmodule

module id_ex_buf #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
  logic                          push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = rdy & in_valid & in_ready  & ~flush;
  assign pop  = rdy & out_valid & out_ready & ~flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    id_ex_buf_entry #(.WIDTH(WIDTH)) u_ent (
      .clk (clk),
      .we  (push && (wr_ptr_q == PW'(i))),
      .d   (in_data),
      .q   (mem_q[i])
    );
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_id_ex_buf.sv
// Randomised and directed bench for id_ex_buf against a queue-based FIFO model.

module tb_id_ex_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int n_pass = 0;
  int n_tot  = 0;
  logic [WIDTH-1:0] q[$];

  id_ex_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_head();
    return (q.size() == 0) ? '0 : q[0];
  endfunction

  // Apply current inputs at the next rising edge, update the model, settle.
  task automatic tick();
    bit do_push, do_pop;
    do_push = rdy && in_valid && (q.size() < DEPTH) && !flush;
    do_pop  = rdy && out_ready && (q.size() > 0) && !flush;
    @(posedge clk);
    if (rdy && flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic idle();
    rdy = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #12;
    n_tot++; if (count !== '0)    $display("FAIL reset_count got %0d exp 0", count);    else n_pass++;
    n_tot++; if (out_valid !== 0) $display("FAIL reset_valid got %0b exp 0", out_valid); else n_pass++;
    n_tot++; if (out_data !== '0) $display("FAIL reset_data got %h exp 0", out_data);   else n_pass++;
    n_tot++; if (in_ready !== 1)  $display("FAIL reset_ready got %0b exp 1", in_ready);  else n_pass++;
    @(negedge clk); rst = 1; q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    idle(); in_valid = 1; in_data = 32'h11;
    tick();
    n_tot++; if (out_valid !== 1 || out_data !== 32'h11 || count !== 1)
      $display("FAIL single_push got v=%0b d=%h c=%0d exp v=1 d=11 c=1", out_valid, out_data, count);
    else n_pass++;
    in_valid = 0; out_ready = 1;
    tick();
    n_tot++; if (out_valid !== 0 || out_data !== '0 || count !== 0)
      $display("FAIL single_pop got v=%0b d=%h c=%0d exp v=0 d=0 c=0", out_valid, out_data, count);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] vals [3];
    vals = '{32'hA1, 32'hA2, 32'hA3};
    idle(); in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      tick();
      if (i == 1) begin
        n_tot++; if (count !== 2 || in_ready !== 0)
          $display("FAIL fill_full got c=%0d r=%0b exp c=2 r=0", count, in_ready);
        else n_pass++;
      end
    end
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      n_tot++; if (out_data !== vals[i] || out_valid !== 1)
        $display("FAIL fill_drain%0d got %h exp %h", i, out_data, vals[i]);
      else n_pass++;
      tick();
    end
    n_tot++; if (count !== 0 || out_data !== '0)
      $display("FAIL fill_empty got c=%0d d=%h exp c=0 d=0", count, out_data);
    else n_pass++;
  endtask

  task automatic test_stream();
    idle(); in_valid = 1; in_data = 1;
    tick();
    out_ready = 1;
    for (int v = 2; v <= 11; v++) begin
      n_tot++; if (out_data !== WIDTH'(v-1) || count !== 1)
        $display("FAIL stream%0d got d=%h c=%0d exp d=%h c=1", v-1, out_data, count, v-1);
      else n_pass++;
      in_data = WIDTH'(v);
      if (v == 11) in_valid = 0;
      tick();
    end
    n_tot++; if (count !== 0) $display("FAIL stream_end got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_flush();
    idle(); in_valid = 1;
    in_data = 32'h5; tick();
    in_data = 32'h6; tick();
    in_data = 32'hFF; flush = 1; out_ready = 1;
    n_tot++; if (in_ready !== 0) $display("FAIL flush_pre got r=%0b exp 0", in_ready); else n_pass++;
    tick();
    n_tot++; if (count !== 0 || out_valid !== 0 || out_data !== '0)
      $display("FAIL flush got c=%0d v=%0b d=%h exp 0/0/0", count, out_valid, out_data);
    else n_pass++;
    flush = 0; in_valid = 0; out_ready = 0;
    tick();
    n_tot++; if (out_data === 32'hFF || count !== 0)
      $display("FAIL flush_leak got c=%0d d=%h exp c=0 d=0", count, out_data);
    else n_pass++;
    // one empty flush with a push: push must be discarded, in_ready stays high
    in_valid = 1; in_data = 32'h77; flush = 1;
    n_tot++; if (in_ready !== 1) $display("FAIL flush_ready got %0b exp 1", in_ready); else n_pass++;
    tick();
    n_tot++; if (count !== 0) $display("FAIL flush_push got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_rdy();
    idle(); in_valid = 1; in_data = 32'h31; tick();
    in_data = 32'h32; tick();
    out_ready = 1; in_data = 32'h99; flush = 1; rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tot++; if (count !== 2 || out_data !== 32'h31)
        $display("FAIL rdy_hold%0d got c=%0d d=%h exp c=2 d=31", i, count, out_data);
      else n_pass++;
    end
    rdy = 1; flush = 0; in_valid = 0;
    tick();
    n_tot++; if (out_data !== 32'h32 || count !== 1)
      $display("FAIL rdy_resume got c=%0d d=%h exp c=1 d=32", count, out_data);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    idle(); in_valid = 1; in_data = 32'h41; tick();
    in_data = 32'h42; tick();
    in_valid = 0;
    #2 rst = 0;
    #1;
    n_tot++; if (count !== 0 || out_valid !== 0 || out_data !== '0 || in_ready !== 1)
      $display("FAIL async_rst got c=%0d v=%0b d=%h r=%0b exp 0/0/0/1", count, out_valid, out_data, in_ready);
    else n_pass++;
    q.delete();
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    n_tot++; if (count !== 0) $display("FAIL async_rst_rel got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    idle();
    for (int i = 0; i < 400; i++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_data   = $urandom;
      tick();
      n_tot++;
      if (count !== CW'(q.size()) || out_valid !== (q.size() != 0) ||
          in_ready !== (q.size() != DEPTH) || out_data !== m_head()) begin
        if (errs < 10)
          $display("FAIL random%0d got c=%0d v=%0b r=%0b d=%h exp c=%0d d=%h",
                   i, count, out_valid, in_ready, out_data, q.size(), m_head());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_rdy();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
